seq_table_loader: RTL and testbench

SEQ_TABLE_LOADER -- requirements
Module: seq_table_loader

---
 rtl/seq_table_loader.sv | 102 ++++++++++
 tb/tb_seq_table_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_table_loader.sv
// seq_table_loader: assembles 32-bit table words into 128-bit frames, commits a length and serves registered frame reads
module seq_table_loader #(
   parameter int SEQ_LEN = 1024
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       TABLE_START,
   input  logic [31:0]                TABLE_DATA,
   input  logic                       TABLE_WSTB,
   input  logic [15:0]                TABLE_LENGTH,
   input  logic                       TABLE_LENGTH_WSTB,
   input  logic                       rd_en_i,
   input  logic [$clog2(SEQ_LEN)-1:0] rd_addr_i,
   output logic [127:0]               rd_data_o,
   output logic                       rd_valid_o,
   output logic [15:0]                frame_count_o,
   output logic                       table_ready_o,
   output logic                       load_error_o
);
   localparam int AW = $clog2(SEQ_LEN);
   typedef enum logic [1:0] {IDLE, LOADING, READY} state_t;
   state_t        r_state;
   logic [1:0]    r_widx;
   logic [AW:0]   r_fptr;
   logic [95:0]   r_asm;
   logic [15:0]   r_fc;
   logic          r_err;
   logic          r_ready;
   logic [127:0]  r_rd_data;
   logic          r_rd_valid;
   logic [127:0]  r_mem [SEQ_LEN];
   logic          w_acc;
   logic          w_last;
   logic          w_full;
   logic          w_wr;
   logic          w_ovf;
   logic [AW:0]   w_fptr_nxt;
   logic [1:0]    w_widx_nxt;
   logic [15:0]   w_nfr;
   logic          w_ok;
   // Words are only taken while loading, never alongside a START, and not once the table has overflowed
   assign w_acc      = (r_state == LOADING) && TABLE_WSTB && !TABLE_START && !r_err;
   assign w_last     = w_acc && (r_widx == 2'd3);
   assign w_full     = r_fptr == (AW+1)'(SEQ_LEN);
   assign w_wr       = w_last && !w_full;
   assign w_ovf      = w_last && w_full;
   assign w_fptr_nxt = r_fptr + (AW+1)'(w_wr);
   assign w_widx_nxt = r_widx + 2'(w_acc);
   assign w_nfr      = {2'b00, TABLE_LENGTH[15:2]};
   // Commit check uses post-word values so a word arriving with the length strobe counts
   assign w_ok       = (TABLE_LENGTH != 16'd0) && (TABLE_LENGTH[1:0] == 2'd0) &&
                       (w_nfr <= 16'(SEQ_LEN)) && (w_nfr == 16'(w_fptr_nxt)) &&
                       (w_widx_nxt == 2'd0) && !r_err && !w_ovf;
   // Load FSM: START restarts from anywhere, words assemble frames, length strobe commits
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= IDLE;
         r_widx  <= 2'd0;
         r_fptr  <= '0;
         r_fc    <= 16'd0;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
      end else if (TABLE_START) begin
         r_state <= LOADING;
         r_widx  <= 2'd0;
         r_fptr  <= '0;
         r_fc    <= 16'd0;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
      end else if (r_state == LOADING) begin
         if (w_acc && r_widx != 2'd3) r_asm[{r_widx, 5'd0} +: 32] <= TABLE_DATA;
         r_widx <= w_widx_nxt;
         r_fptr <= w_fptr_nxt;
         if (w_ovf) r_err <= 1'b1;
         if (TABLE_LENGTH_WSTB) begin
            r_state <= w_ok ? READY : IDLE;
            r_ready <= w_ok;
            r_fc    <= w_ok ? w_nfr : 16'd0;
            if (!w_ok) r_err <= 1'b1;
         end
      end
   end
   // Frame store write port; the fourth word goes straight in alongside the three assembled ones
   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_fptr[AW-1:0]] <= {TABLE_DATA, r_asm};
   end
   // Registered read port; reading the slot being written returns the old frame
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= 128'd0;
      end else begin
         r_rd_valid <= rd_en_i;
         if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
      end
   end
   assign rd_data_o     = r_rd_data;
   assign rd_valid_o    = r_rd_valid;
   assign frame_count_o = r_fc;
   assign table_ready_o = r_ready;
   assign load_error_o  = r_err;
endmodule

// File: tb/tb_seq_table_loader.sv
// tb_seq_table_loader: scoreboard bench for seq_table_loader at depth 1024 plus a depth-4 copy for overflow
module tb_seq_table_loader;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   data = 32'd0;
   logic          wstb = 1'b0;
   logic [15:0]   len = 16'd0;
   logic          lwstb = 1'b0;
   logic          rd_en = 1'b0;
   logic [9:0]    rd_addr = 10'd0;
   logic [127:0]  rd_data, rd_data4;
   logic          rd_valid, rd_valid4;
   logic [15:0]   fc, fc4;
   logic          ready, ready4;
   logic          err, err4;
   logic [127:0]  q [$];
   logic [127:0]  q4 [$];
   int            n_cmp = 0;
   int            n_bad = 0;
   always #5 clk = ~clk;
   seq_table_loader #(.SEQ_LEN(1024)) dut (
      .clk_i(clk), .reset_i(rst), .TABLE_START(start), .TABLE_DATA(data), .TABLE_WSTB(wstb),
      .TABLE_LENGTH(len), .TABLE_LENGTH_WSTB(lwstb), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .frame_count_o(fc), .table_ready_o(ready),
      .load_error_o(err));
   seq_table_loader #(.SEQ_LEN(4)) dut4 (
      .clk_i(clk), .reset_i(rst), .TABLE_START(start), .TABLE_DATA(data), .TABLE_WSTB(wstb),
      .TABLE_LENGTH(len), .TABLE_LENGTH_WSTB(lwstb), .rd_en_i(rd_en), .rd_addr_i(rd_addr[1:0]),
      .rd_data_o(rd_data4), .rd_valid_o(rd_valid4), .frame_count_o(fc4), .table_ready_o(ready4),
      .load_error_o(err4));
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [127:0] fr(input logic [31:0] a, b, c, d);
      return {d, c, b, a};
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic go;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   task automatic word(input logic [31:0] d);
      wstb = 1'b1;
      data = d;
      tick();
      wstb = 1'b0;
   endtask
   task automatic commit(input logic [15:0] l);
      len = l;
      lwstb = 1'b1;
      tick();
      lwstb = 1'b0;
   endtask
   task automatic rd(input logic [9:0] a, input logic [127:0] exp, input logic both);
      rd_en = 1'b1;
      rd_addr = a;
      q.push_back(exp);
      if (both) q4.push_back(exp);
      tick();
      rd_en = 1'b0;
   endtask
   // Read responses are popped from the scoreboard as the DUTs present them
   always @(negedge clk) begin
      if (rd_valid) begin
         if (q.size() == 0) chk("rd_unexpected", 128'(q.size()), 128'd1);
         else chk("rd_data", rd_data, q.pop_front());
      end
      if (rd_valid4 && q4.size() != 0) chk("rd_data4", rd_data4, q4.pop_front());
   end
   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", 128'(ready), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_fc", 128'(fc), 128'd0);
      chk("rst_valid", 128'(rd_valid), 128'd0);
      chk("rst_data", rd_data, 128'd0);
      go();
      for (int i = 1; i <= 8; i++) word(32'(i));
      commit(16'd8);
      chk("t1_ready", 128'(ready), 128'd1);
      chk("t1_fc", 128'(fc), 128'd2);
      chk("t1_err", 128'(err), 128'd0);
      rd(10'd1, 128'h00000008_00000007_00000006_00000005, 1'b0);
      chk("t1_valid", 128'(rd_valid), 128'd1);
      rd(10'd0, fr(1, 2, 3, 4), 1'b0);
      go();
      for (int i = 0; i < 6; i++) word(32'h11 + 32'(i));
      commit(16'd6);
      chk("t2_err", 128'(err), 128'd1);
      chk("t2_ready", 128'(ready), 128'd0);
      chk("t2_fc", 128'(fc), 128'd0);
      go();
      for (int i = 1; i <= 8; i++) word(32'(i));
      commit(16'd8);
      chk("t3_pre_ready", 128'(ready), 128'd1);
      go();
      chk("t3_start_ready", 128'(ready), 128'd0);
      word(32'hA);
      word(32'hB);
      word(32'hC);
      lwstb = 1'b1;
      len = 16'd4;
      word(32'hD);
      lwstb = 1'b0;
      chk("t3_ready", 128'(ready), 128'd1);
      chk("t3_fc", 128'(fc), 128'd1);
      rd(10'd0, fr(32'hA, 32'hB, 32'hC, 32'hD), 1'b0);
      go();
      for (int i = 1; i <= 20; i++) word(32'(i));
      commit(16'd20);
      chk("t4_err4", 128'(err4), 128'd1);
      chk("t4_ready4", 128'(ready4), 128'd0);
      chk("t4_fc4", 128'(fc4), 128'd0);
      chk("t4_fc_big", 128'(fc), 128'd5);
      for (int f = 0; f < 4; f++)
         rd(10'(f), fr(32'(4*f+1), 32'(4*f+2), 32'(4*f+3), 32'(4*f+4)), 1'b1);
      go();
      word(32'h31);
      word(32'h32);
      word(32'h33);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_ready", 128'(ready), 128'd0);
      chk("t5_err", 128'(err), 128'd0);
      chk("t5_fc", 128'(fc), 128'd0);
      chk("t5_data", rd_data, 128'd0);
      chk("t5_valid", 128'(rd_valid), 128'd0);
      for (int i = 0; i < 5; i++) word(32'h50 + 32'(i));
      commit(16'd4);
      chk("t5_post_ready", 128'(ready), 128'd0);
      chk("t5_post_err", 128'(err), 128'd0);
      rd(10'd0, fr(1, 2, 3, 4), 1'b0);
      for (int i = 0; i < 4; i++) word(32'h71 + 32'(i));
      start = 1'b1;
      word(32'hEE);
      start = 1'b0;
      word(32'h61);
      word(32'h62);
      word(32'h63);
      rd_en = 1'b1;
      rd_addr = 10'd0;
      q.push_back(fr(1, 2, 3, 4));
      word(32'h64);
      rd_en = 1'b0;
      commit(16'd4);
      chk("t6_ready", 128'(ready), 128'd1);
      chk("t6_fc", 128'(fc), 128'd1);
      rd(10'd0, fr(32'h61, 32'h62, 32'h63, 32'h64), 1'b0);
      tick();
      chk("hold_data", rd_data, fr(32'h61, 32'h62, 32'h63, 32'h64));
      chk("hold_valid", 128'(rd_valid), 128'd0);
      commit(16'd8);
      chk("t7_ready_ign", 128'(ready), 128'd1);
      chk("t7_fc_ign", 128'(fc), 128'd1);
      start = 1'b1;
      commit(16'd4);
      start = 1'b0;
      chk("t8_ready", 128'(ready), 128'd0);
      chk("t8_fc", 128'(fc), 128'd0);
      chk("t8_err", 128'(err), 128'd0);
      commit(16'd0);
      chk("t8_zero_err", 128'(err), 128'd1);
      chk("t8_zero_ready", 128'(ready), 128'd0);
      tick();
      tick();
      chk("q_empty", 128'(q.size()), 128'd0);
      chk("q4_empty", 128'(q4.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
